// File: rtl/onehot_seq_pkg.sv
// Shared types and helpers for the one-hot stimulus sequencer and its checkers.
package onehot_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned IDX_W     = $clog2(WIDTH_DEF);

  // Reference code for a given index at the default width.
  function automatic logic [WIDTH_DEF-1:0] onehot_of(input logic [IDX_W-1:0] idx);
    return WIDTH_DEF'(1) << idx;
  endfunction

endpackage

// File: rtl/onehot_sequencer_dwell_timer.sv
// Dwell counter: counts cycles a code has been held; flags when the hold is complete.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic [DWELL_W-1:0] i_dwell_q,
  output logic               o_term_c
);

  logic [DWELL_W-1:0] r_count;

  // Cleared on every code change, so it never exceeds the captured dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DWELL_W'(1);
    end
  end

  assign o_term_c = (r_count == i_dwell_q);

endmodule

// File: rtl/onehot_sequencer.sv
// Timed one-hot sweep generator with matching binary index, for driving an encoder under test.
module onehot_sequencer
  import onehot_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode_cont,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [WIDTH-1:0]         onehot_out,
  output logic [$clog2(WIDTH)-1:0] index_out,
  output logic                     strobe,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned OH_IDX_W = $clog2(WIDTH);
  localparam logic [1:0]  S_IDLE   = ST_IDLE;
  localparam logic [1:0]  S_RUN    = ST_RUN;
  localparam logic [1:0]  S_FIN    = ST_FIN;
  localparam logic [OH_IDX_W-1:0] LAST_IDX = OH_IDX_W'(WIDTH - 1);

  logic [1:0]          r_state;
  logic [WIDTH-1:0]    r_onehot;
  logic [OH_IDX_W-1:0] r_index;
  logic                r_strobe;
  logic                r_busy;
  logic                r_done;
  logic [DWELL_W-1:0]  r_dwell_q;
  logic                r_cont_q;

  logic [1:0]          w_nxt_state;
  logic [WIDTH-1:0]    w_nxt_onehot;
  logic [OH_IDX_W-1:0] w_nxt_index;
  logic                w_nxt_strobe;
  logic                w_nxt_busy;
  logic                w_nxt_done;
  logic [DWELL_W-1:0]  w_nxt_dwell_q;
  logic                w_nxt_cont_q;
  logic                w_tmr_clr;
  logic                w_term;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_tmr_clr),
    .i_dwell_q (r_dwell_q),
    .o_term_c  (w_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_onehot  <= '0;
      r_index   <= '0;
      r_strobe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dwell_q <= '0;
      r_cont_q  <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_onehot  <= w_nxt_onehot;
      r_index   <= w_nxt_index;
      r_strobe  <= w_nxt_strobe;
      r_busy    <= w_nxt_busy;
      r_done    <= w_nxt_done;
      r_dwell_q <= w_nxt_dwell_q;
      r_cont_q  <= w_nxt_cont_q;
    end
  end

  // Next state and next output values; stop outranks both start and advance.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_onehot  = '0;
    w_nxt_index   = '0;
    w_nxt_strobe  = 1'b0;
    w_nxt_busy    = 1'b0;
    w_nxt_done    = 1'b0;
    w_nxt_dwell_q = r_dwell_q;
    w_nxt_cont_q  = r_cont_q;
    w_tmr_clr     = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_nxt_state   = S_RUN;
          w_nxt_onehot  = WIDTH'(1);
          w_nxt_strobe  = 1'b1;
          w_nxt_busy    = 1'b1;
          w_nxt_dwell_q = dwell;
          w_nxt_cont_q  = mode_cont;
        end
      end

      S_RUN: begin
        if (stop) begin
          w_nxt_state = S_IDLE;
        end else if (!w_term) begin
          w_nxt_onehot = r_onehot;
          w_nxt_index  = r_index;
          w_nxt_busy   = 1'b1;
          w_tmr_clr    = 1'b0;
        end else if (r_index != LAST_IDX) begin
          w_nxt_onehot = r_onehot << 1;
          w_nxt_index  = r_index + OH_IDX_W'(1);
          w_nxt_strobe = 1'b1;
          w_nxt_busy   = 1'b1;
        end else if (r_cont_q) begin
          w_nxt_onehot = WIDTH'(1);
          w_nxt_strobe = 1'b1;
          w_nxt_busy   = 1'b1;
        end else begin
          w_nxt_state = S_FIN;
          w_nxt_done  = 1'b1;
        end
      end

      S_FIN: begin
        w_nxt_state = S_IDLE;
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  assign onehot_out = r_onehot;
  assign index_out  = r_index;
  assign strobe     = r_strobe;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_onehot_sequencer.sv
// Directed bench for onehot_sequencer with a sweep-position model checked every cycle.
module tb_onehot_sequencer;
  import onehot_seq_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          mode_cont;
  logic [DW-1:0] dwell;
  logic [W-1:0]  onehot_out;
  logic [2:0]    index_out;
  logic          strobe;
  logic          busy;
  logic          done;

  int n_vec;
  int n_err;

  onehot_sequencer #(
    .WIDTH   (W),
    .DWELL_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode_cont  (mode_cont),
    .dwell      (dwell),
    .onehot_out (onehot_out),
    .index_out  (index_out),
    .strobe     (strobe),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a running sweep is just a cycle position; code = (pos / hold) mod W.
  bit m_run;
  bit m_done;
  bit m_cont;
  int m_pos;
  int m_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  = 0;
      m_done = 0;
      m_cont = 0;
      m_pos  = 0;
      m_hold = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (stop) begin
        m_run = 0;
      end else begin
        m_pos = m_pos + 1;
        if (!m_cont && m_pos == int'(W) * m_hold) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end else if (start && !stop) begin
      m_run  = 1;
      m_pos  = 0;
      m_hold = int'(dwell) + 1;
      m_cont = mode_cont;
    end
  end

  function automatic int exp_idx();
    return m_run ? (m_pos / m_hold) % int'(W) : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_onehot", 32'(onehot_out), m_run ? (32'd1 << exp_idx()) : 32'd0);
    chk("model_index",  32'(index_out),  32'(exp_idx()));
    chk("model_strobe", 32'(strobe),     32'(m_run && (m_pos % m_hold == 0)));
    chk("model_busy",   32'(busy),       32'(m_run));
    chk("model_done",   32'(done),       32'(m_done));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy || done) && g < 5000) begin
      tick(1);
      g++;
    end
    chk("idle_timeout", 32'(busy | done), 32'd0);
  endtask

  logic [W-1:0] exp_seq [8];

  initial begin
    int cnt;
    int scnt;
    int g;
    logic [2:0] five;

    n_vec = 0;
    n_err = 0;
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0; dwell = '0;
    tick(3);
    chk("reset_onehot", 32'(onehot_out), 32'd0);
    chk("reset_busy",   32'(busy | strobe | done), 32'd0);
    five = 3'd5;
    chk("pkg_onehot_of", 32'(onehot_of(five)), 32'h20);
    rst_n = 1'b1;
    tick(2);

    // Fast single sweep, one code per cycle.
    start = 1'b1; dwell = 8'd0; mode_cont = 1'b0;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("fast_code",   32'(onehot_out), 32'(exp_seq[i]));
      chk("fast_index",  32'(index_out), 32'(i));
      chk("fast_strobe", 32'(strobe & busy), 32'd1);
      tick(1);
    end
    chk("fast_done",      32'(done), 32'd1);
    chk("fast_done_zero", 32'(onehot_out | 8'(busy)), 32'd0);
    tick(1);
    chk("fast_done_once", 32'(done), 32'd0);
    tick(2);

    // Long dwell single sweep.
    start = 1'b1; dwell = 8'd99;
    tick(1);
    start = 1'b0;
    dwell = 8'd5;
    cnt = busy ? 1 : 0;
    scnt = strobe ? 1 : 0;
    g = 0;
    while (busy && g < 2000) begin
      tick(1);
      g++;
      if (busy) begin
        cnt++;
        if (strobe) scnt++;
      end
    end
    chk("long_busy_cycles", 32'(cnt), 32'd800);
    chk("long_strobes",     32'(scnt), 32'd8);
    chk("long_done",        32'(done), 32'd1);
    wait_idle();

    // Continuous wrap, then stop.
    start = 1'b1; dwell = 8'd2; mode_cont = 1'b1;
    tick(1);
    start = 1'b0; mode_cont = 1'b0;
    tick(21);
    chk("cont_last_code", 32'(onehot_out), 32'h80);
    tick(3);
    chk("cont_wrap_code",   32'(onehot_out), 32'h01);
    chk("cont_wrap_strobe", 32'(strobe), 32'd1);
    chk("cont_wrap_index",  32'(index_out), 32'd0);
    tick(6);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_zero", 32'(onehot_out | 8'(busy) | 8'(done) | 8'(strobe)), 32'd0);
    tick(1);
    chk("stop_no_done", 32'(done), 32'd0);
    tick(2);

    // start and stop together from idle.
    start = 1'b1; stop = 1'b1; dwell = 8'd0;
    tick(2);
    chk("startstop_idle", 32'(onehot_out | 8'(busy)), 32'd0);
    start = 1'b0; stop = 1'b0;
    tick(2);

    // Restart attempt mid-sweep is ignored.
    start = 1'b1; dwell = 8'd0;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("rerun_at_04", 32'(onehot_out), 32'h04);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("rerun_continues", 32'(onehot_out), 32'h08);
    wait_idle();
    tick(2);

    // Asynchronous reset mid-sweep.
    start = 1'b1; dwell = 8'd3;
    tick(1);
    start = 1'b0;
    tick(17);
    chk("areset_pre", 32'(onehot_out), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_immediate", 32'(onehot_out | 8'(busy)), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("areset_quiet", 32'(onehot_out | 8'(busy) | 8'(done)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
